// File: rtl/rcoef_collect.sv
// Bit-slice to word collector: reassembles K LSB-first serial
// coefficients of N bits each and offers them under valid/ready.
module rcoef_collect #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           slice_valid,
  input  logic [K-1:0]   slice,
  output logic [K*N-1:0] rdata,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output logic           overrun
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t state, state_n;

  logic [K*N-1:0] data_q;
  logic [CW-1:0]  count;
  logic           ovr_q;
  logic           clr;
  logic           shift;

  always_comb begin
    state_n = state;
    clr     = 1'b0;
    shift   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = COLLECT;
          clr     = 1'b1;
        end
      end
      COLLECT: begin
        if (slice_valid) begin
          shift = 1'b1;
          if (count == LAST)
            state_n = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (start) begin
            state_n = COLLECT;
            clr     = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      data_q <= '0;
      count  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (clr) begin
        data_q <= '0;
        count  <= '0;
      end else if (shift) begin
        // each new bit enters at the MSB so the first lands in bit 0
        for (int i = 0; i < K; i++)
          data_q[i*N +: N] <= {slice[i], data_q[i*N+1 +: N-1]};
        count <= count + 1'b1;
      end
      if (state == HOLD && slice_valid)
        ovr_q <= 1'b1;
    end
  end

  assign rdata     = data_q;
  assign out_valid = (state == HOLD);
  assign busy      = (state == COLLECT);
  assign overrun   = ovr_q;

endmodule
